// File: rtl/encoder_83_seq.sv
// Sequential 8-to-3 encoder: serialises the set bits of a request vector into indices over a valid/ready handshake.
// Define ENC83_MSB_FIRST_EN to emit the highest set index first (default: lowest first).
module encoder_83_seq (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] req_in,
  input  logic       req_valid,
  output logic       req_ready,
  output logic [2:0] idx,
  output logic       idx_valid,
  input  logic       idx_ready,
  output logic       idx_last,
  output logic [3:0] pend_cnt,
  output logic       zero_err
);

  typedef enum logic {IDLE, SERVE} state_t;

  state_t     state, state_n;
  logic [7:0] pending, pending_n;
  logic [2:0] idx_n;
  logic       idx_valid_n, idx_last_n, zero_err_n;
  logic [3:0] pend_cnt_n;

  function automatic logic [2:0] prio_bit(input logic [7:0] v);
    logic [2:0] r;
    r = 3'd0;
`ifdef ENC83_MSB_FIRST_EN
    for (int i = 0; i < 8; i++)
      if (v[i]) r = 3'(i);
`else
    for (int i = 7; i >= 0; i--)
      if (v[i]) r = 3'(i);
`endif
    return r;
  endfunction

  function automatic logic [3:0] popcount(input logic [7:0] v);
    logic [3:0] c;
    c = 4'd0;
    for (int i = 0; i < 8; i++)
      c = c + 4'(v[i]);
    return c;
  endfunction

  assign req_ready = (state == IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      pending   <= 8'd0;
      idx       <= 3'd0;
      idx_valid <= 1'b0;
      idx_last  <= 1'b0;
      pend_cnt  <= 4'd0;
      zero_err  <= 1'b0;
    end else begin
      state     <= state_n;
      pending   <= pending_n;
      idx       <= idx_n;
      idx_valid <= idx_valid_n;
      idx_last  <= idx_last_n;
      pend_cnt  <= pend_cnt_n;
      zero_err  <= zero_err_n;
    end
  end

  always_comb begin
    state_n     = state;
    pending_n   = pending;
    idx_n       = idx;
    idx_valid_n = idx_valid;
    idx_last_n  = idx_last;
    pend_cnt_n  = pend_cnt;
    zero_err_n  = 1'b0;
    unique case (state)
      IDLE: begin
        if (req_valid) begin
          if (req_in != 8'd0) begin
            state_n     = SERVE;
            pending_n   = req_in;
            idx_n       = prio_bit(req_in);
            idx_valid_n = 1'b1;
            idx_last_n  = (popcount(req_in) == 4'd1);
            pend_cnt_n  = popcount(req_in);
          end else begin
            zero_err_n = 1'b1;
          end
        end
      end
      SERVE: begin
        // The final handshake empties pending, so the count drops straight to zero here.
        if (idx_valid && idx_ready) begin
          pending_n = pending & ~(8'd1 << idx);
          if (idx_last) begin
            state_n     = IDLE;
            pending_n   = 8'd0;
            idx_n       = 3'd0;
            idx_valid_n = 1'b0;
            idx_last_n  = 1'b0;
            pend_cnt_n  = 4'd0;
          end else begin
            idx_n      = prio_bit(pending & ~(8'd1 << idx));
            pend_cnt_n = pend_cnt - 4'd1;
            idx_last_n = (pend_cnt == 4'd2);
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_encoder_83_seq.sv
// Directed self-checking bench for encoder_83_seq; honours ENC83_MSB_FIRST_EN for expected index order.
module tb_encoder_83_seq;

  logic       clk;
  logic       rst;
  logic [7:0] req_in;
  logic       req_valid;
  logic       req_ready;
  logic [2:0] idx;
  logic       idx_valid;
  logic       idx_ready;
  logic       idx_last;
  logic [3:0] pend_cnt;
  logic       zero_err;

  int total = 0;
  int bad   = 0;

  encoder_83_seq dut (
    .clk(clk), .rst(rst), .req_in(req_in), .req_valid(req_valid),
    .req_ready(req_ready), .idx(idx), .idx_valid(idx_valid),
    .idx_ready(idx_ready), .idx_last(idx_last), .pend_cnt(pend_cnt),
    .zero_err(zero_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [7:0] data, input logic rdy);
    req_valid = v;
    req_in    = data;
    idx_ready = rdy;
  endtask

  // Expected index for the n-th emission of a vector whose set bits are listed in ascending order.
  function automatic logic [2:0] order_pick(input logic [2:0] asc [8], input int count, input int n);
`ifdef ENC83_MSB_FIRST_EN
    return asc[count-1-n];
`else
    return asc[n];
`endif
  endfunction

  initial begin
    logic [2:0] a5 [8];
    logic [2:0] ff [8];
    int emitted;
    logic rdy;
    a5 = '{3'd0, 3'd2, 3'd5, 3'd7, 3'd0, 3'd0, 3'd0, 3'd0};
    ff = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7};

    rst = 1'b1;
    applyStimulus(1'b0, 8'h00, 1'b0);
    @(negedge clk);
    @(negedge clk);
    checkOutput("rst_idx_valid", 8'(idx_valid), 8'd0);
    checkOutput("rst_pend_cnt", 8'(pend_cnt), 8'd0);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("init_req_ready", 8'(req_ready), 8'd1);
    checkOutput("init_idx", 8'(idx), 8'd0);
    checkOutput("init_idx_last", 8'(idx_last), 8'd0);
    checkOutput("init_zero_err", 8'(zero_err), 8'd0);

    $display("[TB] one-hot sweep");
    for (int k = 0; k < 8; k++) begin
      applyStimulus(1'b1, 8'd1 << k, 1'b1);
      @(negedge clk);
      checkOutput("oh_idx", 8'(idx), 8'(k));
      checkOutput("oh_valid", 8'(idx_valid), 8'd1);
      checkOutput("oh_last", 8'(idx_last), 8'd1);
      checkOutput("oh_cnt", 8'(pend_cnt), 8'd1);
      checkOutput("oh_req_ready", 8'(req_ready), 8'd0);
      applyStimulus(1'b0, 8'h00, 1'b1);
      @(negedge clk);
      checkOutput("oh_back_idle", 8'(req_ready), 8'd1);
      checkOutput("oh_valid_low", 8'(idx_valid), 8'd0);
    end

    $display("[TB] multi-hot A5");
    applyStimulus(1'b1, 8'hA5, 1'b1);
    for (int n = 0; n < 4; n++) begin
      @(negedge clk);
      applyStimulus(1'b0, 8'h00, 1'b1);
      checkOutput("a5_idx", 8'(idx), 8'(order_pick(a5, 4, n)));
      checkOutput("a5_cnt", 8'(pend_cnt), 8'(4 - n));
      checkOutput("a5_last", 8'(idx_last), 8'(n == 3));
      checkOutput("a5_valid", 8'(idx_valid), 8'd1);
    end
    @(negedge clk);
    checkOutput("a5_req_ready", 8'(req_ready), 8'd1);
    checkOutput("a5_valid_low", 8'(idx_valid), 8'd0);

    $display("[TB] backpressure FF");
    applyStimulus(1'b1, 8'hFF, 1'b0);
    @(negedge clk);
    emitted = 0;
    for (int cyc = 0; cyc < 40 && emitted < 8; cyc++) begin
      checkOutput("bp_idx", 8'(idx), 8'(order_pick(ff, 8, emitted)));
      checkOutput("bp_cnt", 8'(pend_cnt), 8'(8 - emitted));
      checkOutput("bp_last", 8'(idx_last), 8'(emitted == 7));
      checkOutput("bp_valid", 8'(idx_valid), 8'd1);
      checkOutput("bp_req_ready", 8'(req_ready), 8'd0);
      rdy = (cyc % 3 == 0);
      applyStimulus(cyc[0], 8'h01, rdy);
      if (rdy) emitted++;
      @(negedge clk);
    end
    checkOutput("bp_req_ready_end", 8'(req_ready), 8'd1);
    checkOutput("bp_valid_end", 8'(idx_valid), 8'd0);
    checkOutput("bp_cnt_end", 8'(pend_cnt), 8'd0);
    applyStimulus(1'b0, 8'h00, 1'b0);

    $display("[TB] zero vector");
    @(negedge clk);
    applyStimulus(1'b1, 8'h00, 1'b0);
    @(negedge clk);
    checkOutput("zero_err_hi", 8'(zero_err), 8'd1);
    checkOutput("zero_valid", 8'(idx_valid), 8'd0);
    checkOutput("zero_req_ready", 8'(req_ready), 8'd1);
    applyStimulus(1'b0, 8'h00, 1'b0);
    @(negedge clk);
    checkOutput("zero_err_lo", 8'(zero_err), 8'd0);

    $display("[TB] reset mid-serve");
    applyStimulus(1'b1, 8'h0F, 1'b1);
    @(negedge clk);
    applyStimulus(1'b0, 8'h00, 1'b1);
    checkOutput("mid_idx0", 8'(idx), 8'(order_pick(ff, 4, 0) + ((`ifdef ENC83_MSB_FIRST_EN 3'd0 `else 3'd0 `endif))));
    checkOutput("mid_cnt0", 8'(pend_cnt), 8'd4);
    @(negedge clk);
    checkOutput("mid_cnt1", 8'(pend_cnt), 8'd3);
    @(negedge clk);
    checkOutput("mid_cnt2", 8'(pend_cnt), 8'd2);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("mid_rst_valid", 8'(idx_valid), 8'd0);
    checkOutput("mid_rst_cnt", 8'(pend_cnt), 8'd0);
    checkOutput("mid_rst_ready", 8'(req_ready), 8'd1);
    checkOutput("mid_rst_last", 8'(idx_last), 8'd0);
    applyStimulus(1'b1, 8'h10, 1'b1);
    @(negedge clk);
    applyStimulus(1'b0, 8'h00, 1'b1);
    checkOutput("post_idx", 8'(idx), 8'd4);
    checkOutput("post_last", 8'(idx_last), 8'd1);
    checkOutput("post_cnt", 8'(pend_cnt), 8'd1);
    @(negedge clk);
    checkOutput("post_idle", 8'(req_ready), 8'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
